// File: rtl/line_code_serializer_if.sv
// Word handshake between a word source and the line code serializer.
interface line_code_serializer_if #(
   parameter int unsigned DATA_W = 8
) ();
   logic [1:0]        mode;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;

   modport master (output mode, output in_data, output in_valid, input in_ready);
   modport slave  (input mode, input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/line_code_serializer.sv
// Parallel-to-serial line encoder: NRZ, Manchester, differential Manchester, NRZI.
// Two clock cycles (half-bits) per data bit; words stream gaplessly when offered in time.
module line_code_serializer #(
   parameter int unsigned DATA_W     = 8,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter bit          IDLE_LEVEL = 1'b0
) (
   input  logic                   clk,
   input  logic                   reset_b,
   line_code_serializer_if.slave  bus,
   output logic                   line_out,
   output logic                   line_en,
   output logic                   done
);

   localparam int unsigned    CntW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

   localparam logic [0:0] StIdle   = 1'b0;
   localparam logic [0:0] StActive = 1'b1;

   localparam logic [1:0] ModeNrz  = 2'd0;
   localparam logic [1:0] ModeMan  = 2'd1;
   localparam logic [1:0] ModeDiff = 2'd2;
   localparam logic [1:0] ModeNrzi = 2'd3;

   logic [0:0]        state_q, state_d;
   logic [DATA_W-1:0] word_q, word_d;
   logic [1:0]        mode_q, mode_d;
   logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
   logic              phase_q, phase_d;
   logic              line_q, line_d;
   logic              en_q, en_d;

   logic last;
   logic ready;
   logic accept;

   // Position of the n-th transmitted bit inside the word.
   function automatic logic [CntW-1:0] bit_idx(input logic [CntW-1:0] n);
      return MSB_FIRST ? (LastCnt - n) : n;
   endfunction

   // First half-bit level from mode, bit value and the line level before the boundary.
   function automatic logic first_half(input logic [1:0] m, input logic b, input logic p);
      logic lvl;
      case (m)
         ModeNrz, ModeMan: lvl = b;
         ModeDiff:         lvl = p ^ ~b;
         default:          lvl = p ^ b;
      endcase
      return lvl;
   endfunction

   assign last         = (state_q == StActive) && (bit_cnt_q == LastCnt) && phase_q;
   assign ready        = reset_b && ((state_q == StIdle) || last);
   assign accept       = bus.in_valid && ready;
   assign bus.in_ready = ready;
   assign done         = last;
   assign line_out     = line_q;
   assign line_en      = en_q;

   // Next-state: word accept has priority, otherwise step through half-bits.
   always_comb begin
      state_d   = state_q;
      word_d    = word_q;
      mode_d    = mode_q;
      bit_cnt_d = bit_cnt_q;
      phase_d   = phase_q;
      line_d    = line_q;
      en_d      = en_q;
      if (accept) begin
         state_d   = StActive;
         word_d    = bus.in_data;
         mode_d    = bus.mode;
         bit_cnt_d = '0;
         phase_d   = 1'b0;
         en_d      = 1'b1;
         line_d    = first_half(bus.mode, bus.in_data[bit_idx('0)], line_q);
      end else if (state_q == StActive) begin
         if (!phase_q) begin
            phase_d = 1'b1;
            // NRZ/NRZI repeat the level; Manchester variants always invert mid-bit.
            line_d  = (mode_q == ModeNrz || mode_q == ModeNrzi) ? line_q : ~line_q;
         end else if (last) begin
            state_d = StIdle;
            en_d    = 1'b0;
            // Differential codes keep their phase reference across idle gaps.
            line_d  = (mode_q == ModeNrz || mode_q == ModeMan) ? IDLE_LEVEL : line_q;
         end else begin
            phase_d   = 1'b0;
            bit_cnt_d = bit_cnt_q + CntW'(1);
            line_d    = first_half(mode_q, word_q[bit_idx(bit_cnt_q + CntW'(1))], line_q);
         end
      end
   end

   // State registers; reset drops any word in flight.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q   <= StIdle;
         word_q    <= '0;
         mode_q    <= ModeNrz;
         bit_cnt_q <= '0;
         phase_q   <= 1'b0;
         line_q    <= IDLE_LEVEL;
         en_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         word_q    <= word_d;
         mode_q    <= mode_d;
         bit_cnt_q <= bit_cnt_d;
         phase_q   <= phase_d;
         line_q    <= line_d;
         en_q      <= en_d;
      end
   end

endmodule

// File: tb/tb_line_code_serializer.sv
// Bench for line_code_serializer: expected {line_out, line_en, done, in_ready} per cycle
// are queued as stimulus is driven and compared on the falling edge.
module tb_line_code_serializer;

   logic clk;
   logic reset_b;
   logic line_out;
   logic line_en;
   logic done;

   int vectors;
   int errors;

   logic [3:0] exp_q[$];

   line_code_serializer_if #(.DATA_W(8)) bus ();

   line_code_serializer #(
      .DATA_W     (8),
      .MSB_FIRST  (1'b1),
      .IDLE_LEVEL (1'b0)
   ) dut (
      .clk      (clk),
      .reset_b  (reset_b),
      .bus      (bus),
      .line_out (line_out),
      .line_en  (line_en),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Queue one 16-half-bit word: line level from pattern MSB first, done/ready on the last.
   task automatic push_word(input logic [15:0] pat);
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back({pat[15-i], 1'b1, (i == 15), (i == 15)});
      end
   endtask

   task automatic push_idle(input logic lvl, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({lvl, 1'b0, 1'b0, 1'b1});
   endtask

   task automatic test_reset();
      logic [3:0] got;
      reset_b      = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.mode     = 2'd0;
      @(negedge clk);
      got = {line_out, line_en, done, bus.in_ready};
      vectors++;
      if (got !== 4'b0000) begin
         errors++;
         $display("FAIL reset_held got=%b want=%b", got, 4'b0000);
      end
      reset_b = 1'b1;
      #1;
      got = {line_out, line_en, done, bus.in_ready};
      vectors++;
      if (got !== 4'b0001) begin
         errors++;
         $display("FAIL reset_release got=%b want=%b", got, 4'b0001);
      end
      @(negedge clk);
   endtask

   task automatic test_manchester();
      logic [3:0] got, exp;
      int n;
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL man_ready got=%b want=1", bus.in_ready);
      end
      bus.mode = 2'd1; bus.in_data = 8'hA5; bus.in_valid = 1'b1;
      push_word(16'h9966);
      push_idle(1'b0, 2);
      @(negedge clk);
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         exp = exp_q.pop_front();
         got = {line_out, line_en, done, bus.in_ready};
         vectors++;
         if (got !== exp) begin
            errors++;
            $display("FAIL manchester[%0d] got=%b want=%b", i, got, exp);
         end
         if (i == 0) bus.in_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] got, exp;
      int n;
      bus.mode = 2'd0; bus.in_data = 8'hFF; bus.in_valid = 1'b1;
      push_word(16'hFFFF);
      push_word(16'h0000);
      push_idle(1'b0, 2);
      @(negedge clk);
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         exp = exp_q.pop_front();
         got = {line_out, line_en, done, bus.in_ready};
         vectors++;
         if (got !== exp) begin
            errors++;
            $display("FAIL back_to_back[%0d] got=%b want=%b", i, got, exp);
         end
         if (i == 0)  bus.in_data  = 8'h00;
         if (i == 3)  bus.mode     = 2'd3;
         if (i == 10) bus.mode     = 2'd0;
         if (i == 16) bus.in_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_nrzi();
      logic [3:0] got, exp;
      int n;
      bus.mode = 2'd3; bus.in_data = 8'b1100_1010; bus.in_valid = 1'b1;
      push_word(16'hC0F0);
      push_idle(1'b0, 3);
      @(negedge clk);
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         exp = exp_q.pop_front();
         got = {line_out, line_en, done, bus.in_ready};
         vectors++;
         if (got !== exp) begin
            errors++;
            $display("FAIL nrzi[%0d] got=%b want=%b", i, got, exp);
         end
         if (i == 0) bus.in_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_diff_manchester();
      logic [3:0] got, exp;
      int n;
      bus.mode = 2'd2; bus.in_data = 8'h00; bus.in_valid = 1'b1;
      push_word(16'hAAAA);
      push_idle(1'b0, 2);
      push_word(16'h6666);
      push_idle(1'b0, 2);
      @(negedge clk);
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         exp = exp_q.pop_front();
         got = {line_out, line_en, done, bus.in_ready};
         vectors++;
         if (got !== exp) begin
            errors++;
            $display("FAIL diff_manchester[%0d] got=%b want=%b", i, got, exp);
         end
         if (i == 0) bus.in_valid = 1'b0;
         if (i == 17) begin
            bus.in_data  = 8'hFF;
            bus.in_valid = 1'b1;
         end
         if (i == 18) bus.in_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_mid_word_reset();
      logic [3:0] got, exp;
      int n;
      bus.mode = 2'd1; bus.in_data = 8'hA5; bus.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) exp_q.push_back({(i == 0 || i == 3), 1'b1, 1'b0, 1'b0});
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         exp = exp_q.pop_front();
         got = {line_out, line_en, done, bus.in_ready};
         vectors++;
         if (got !== exp) begin
            errors++;
            $display("FAIL pre_reset[%0d] got=%b want=%b", i, got, exp);
         end
         if (i == 0) bus.in_valid = 1'b0;
         @(negedge clk);
      end
      // Half-bit 5 is on the line now; reset must clear outputs without a clock edge.
      reset_b = 1'b0;
      #1;
      got = {line_out, line_en, done, bus.in_ready};
      vectors++;
      if (got !== 4'b0000) begin
         errors++;
         $display("FAIL mid_reset got=%b want=%b", got, 4'b0000);
      end
      @(negedge clk);
      reset_b = 1'b1;
      bus.mode = 2'd0; bus.in_data = 8'h3C; bus.in_valid = 1'b1;
      push_word(16'h0FF0);
      push_idle(1'b0, 2);
      @(negedge clk);
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         exp = exp_q.pop_front();
         got = {line_out, line_en, done, bus.in_ready};
         vectors++;
         if (got !== exp) begin
            errors++;
            $display("FAIL post_reset[%0d] got=%b want=%b", i, got, exp);
         end
         if (i == 0) bus.in_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      test_reset();
      test_manchester();
      test_back_to_back();
      test_nrzi();
      test_diff_manchester();
      test_mid_word_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
